// File: rtl/mem_responder.sv
// mem_responder: memory-side end of the MIO_EN / R_W / a / d_in / mio_out / R bus.
//   Serves word reads/writes from an internal RAM after LATENCY cycles, and
//   decodes the device registers KBSR/KBDR/DSR/DDR/MCR at xFE00-xFFFF.
// Ports:
//   clk, reset (async, active-low)
//   MIO_EN, R_W, a, d_in   : access request from the initiator (held until R)
//   mio_out, R             : read data and one-cycle ready pulse
//   kb_valid, kb_data      : keyboard character strobe in
//   kb_overrun             : pulse when a character is dropped
//   disp_valid, disp_data, disp_ready : display character stream out
//   kb_int, disp_int, mcr_run : interrupt requests and machine-run bit
module mem_responder #(
  parameter int LATENCY    = 2,
  parameter int MEM_ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] a,
  input  logic [15:0] d_in,
  output logic [15:0] mio_out,
  output logic        R,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_overrun,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready,
  output logic        kb_int,
  output logic        disp_int,
  output logic        mcr_run
);

  localparam logic [15:0] KBSR_A   = 16'hFE00;
  localparam logic [15:0] KBDR_A   = 16'hFE02;
  localparam logic [15:0] DSR_A    = 16'hFE04;
  localparam logic [15:0] DDR_A    = 16'hFE06;
  localparam logic [15:0] MCR_A    = 16'hFFFE;
  localparam logic [15:0] DEV_BASE = 16'hFE00;
  localparam int          CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [15:0] a_q;
  logic        rw_q;
  logic [15:0] d_q;

  logic [15:0] mem [0:(1<<MEM_ADDR_W)-1];

  logic        kb_rdy, kb_ie, ds_rdy, ds_ie;
  logic [7:0]  kbd;
  logic [15:0] mcr;

  logic                  accept, commit, c_rw, is_ram;
  logic [15:0]           c_addr, c_data, rd_data;
  logic [MEM_ADDR_W-1:0] ram_idx;
  logic                  kbdr_rd, ddr_wr;

  // With LATENCY=1 the access commits on its acceptance edge, so the live
  // bus fields are used; otherwise the fields captured at acceptance are.
  assign accept  = (state == IDLE) && MIO_EN;
  assign commit  = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == CNT_W'(1)));
  assign c_addr  = (LATENCY == 1) ? a    : a_q;
  assign c_rw    = (LATENCY == 1) ? R_W  : rw_q;
  assign c_data  = (LATENCY == 1) ? d_in : d_q;
  assign is_ram  = (c_addr < DEV_BASE);
  assign ram_idx = c_addr[MEM_ADDR_W-1:0];
  assign kbdr_rd = commit && !c_rw && (c_addr == KBDR_A);
  assign ddr_wr  = commit &&  c_rw && (c_addr == DDR_A);

  assign kb_int   = kb_rdy & kb_ie;
  assign disp_int = ds_rdy & ds_ie;
  assign mcr_run  = mcr[15];

  always_comb begin
    rd_data = 16'h0000;
    if (is_ram) begin
      rd_data = mem[ram_idx];
    end else begin
      case (c_addr)
        KBSR_A:  rd_data = {kb_rdy, kb_ie, 14'h0000};
        KBDR_A:  rd_data = {8'h00, kbd};
        DSR_A:   rd_data = {ds_rdy, ds_ie, 14'h0000};
        MCR_A:   rd_data = mcr;
        default: rd_data = 16'h0000;
      endcase
    end
  end

  // Request capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a;
      rw_q <= R_W;
      d_q  <= d_in;
    end
  end

  // RAM write; gated by reset so a held request cannot commit while in reset
  always_ff @(posedge clk) begin
    if (reset && commit && c_rw && is_ram) begin
      mem[ram_idx] <= c_data;
    end
  end

  // Handshake FSM, read data and device registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      R          <= 1'b0;
      mio_out    <= 16'h0000;
      kb_rdy     <= 1'b0;
      kb_ie      <= 1'b0;
      kbd        <= 8'h00;
      ds_rdy     <= 1'b1;
      ds_ie      <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= 8'h00;
      kb_overrun <= 1'b0;
      mcr        <= 16'h8000;
    end else begin
      R          <= 1'b0;
      kb_overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (MIO_EN) begin
            if (LATENCY == 1) begin
              state <= RESP;
              R     <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
            R     <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (commit && !c_rw) mio_out <= rd_data;

      if (commit && c_rw) begin
        case (c_addr)
          KBSR_A:  kb_ie <= c_data[14];
          DSR_A:   ds_ie <= c_data[14];
          MCR_A:   mcr   <= c_data;
          default: ;
        endcase
      end

      // A KBDR read committing on the same edge frees the slot, so the new
      // character is latched instead of dropped.
      if (kb_valid) begin
        if (!kb_rdy || kbdr_rd) begin
          kbd    <= kb_data;
          kb_rdy <= 1'b1;
        end else begin
          kb_overrun <= 1'b1;
        end
      end else if (kbdr_rd) begin
        kb_rdy <= 1'b0;
      end

      // ds_rdy=1 implies disp_valid=0, so the two updates never collide.
      if (disp_valid && disp_ready) begin
        disp_valid <= 1'b0;
        ds_rdy     <= 1'b1;
      end
      if (ddr_wr && ds_rdy) begin
        disp_data  <= c_data[7:0];
        disp_valid <= 1'b1;
        ds_rdy     <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the processor's memory/IO bus. It is the other end of the MIO_EN / R_W / a / d_in / mio_out / R handshake driven by the datapath.
- Serves reads and writes from an internal word-addressed RAM after a programmable latency.
- Implements the memory-mapped device registers KBSR/KBDR/DSR/DDR/MCR at xFE00–xFFFF, with keyboard-in and display-out streaming ports and interrupt request outputs.

Parameters:
LATENCY, 2, cycles from request acceptance to R assertion (legal range ≥1)
MEM_ADDR_W, 12, RAM depth is 2^MEM_ADDR_W 16-bit words; non-device addresses alias on a[MEM_ADDR_W-1:0]

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
MIO_EN  in  1  access request; held high by initiator until R seen
R_W  in  1  1 = write, 0 = read; stable while MIO_EN high
a  in  16  word address; stable while MIO_EN high
d_in  in  16  write data; stable while MIO_EN high
mio_out  out  16  read data, valid while R high, held until next read completes
R  out  1  ready; one-cycle pulse ending an access
kb_valid  in  1  keyboard character strobe
kb_data  in  8  keyboard character
kb_overrun  out  1  one-cycle pulse: character dropped because KBSR[15]=1
disp_valid  out  1  display character pending
disp_data  out  8  display character
disp_ready  in  1  display consumer accepts when disp_valid&disp_ready
kb_int  out  1  KBSR[15]&KBSR[14]
disp_int  out  1  DSR[15]&DSR[14]
mcr_run  out  1  MCR[15]

Behaviour:
- Reset (reset=0, async): state IDLE, R=0, mio_out=x0000, KBSR=x0000, KBDR=x0000, DSR=x8000, disp_valid=0, disp_data=x00, kb_overrun=0, MCR=x8000. RAM contents are not reset.
- Reset asserted mid-access aborts it. No R is produced. A write not yet committed is never committed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: MIO_EN=1 at an edge → accept and capture a/R_W/d_in. Go to RESP if LATENCY=1, else WAIT with cnt=LATENCY-1.
  - WAIT: decrement cnt each edge; when cnt reaches 1, go to RESP.
  - RESP: R=1 for exactly this cycle, then IDLE.
- Timing: request accepted at edge t gives R high in the cycle after edge t+LATENCY-1, i.e. R rises LATENCY edges after acceptance. R, mio_out and all device state are registered.
- Commit point: the access is performed on the edge on which the FSM enters RESP.
  - Read: mio_out loads the data.
  - Write: RAM or register is updated.
- Back-to-back: MIO_EN high in the IDLE cycle after RESP starts a new access; minimum spacing is one idle cycle.
- Address decode: xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR, xFFFE MCR. Other addresses ≥xFE00 read x0000 and ignore writes. Addresses <xFE00 access RAM[a[MEM_ADDR_W-1:0]].
- KBSR: bit15 ready (read-only), bit14 IE (writable); other bits read 0. KBDR reads {8'h00, char}; writes are ignored.
- KBDR read commit clears KBSR[15].
- kb_valid with KBSR[15]=0: KBDR ← kb_data, KBSR[15] ← 1.
- kb_valid with KBSR[15]=1: character dropped, kb_overrun pulses one cycle.
- Simultaneous kb_valid and KBDR-read commit: read returns the old char, the new char is latched, KBSR[15] stays 1, no overrun.
- DSR: bit15 ready (read-only), bit14 IE (writable). DDR reads x0000.
- DDR write commit with DSR[15]=1: disp_data ← d_in[7:0], disp_valid ← 1, DSR[15] ← 0.
- DDR write commit with DSR[15]=0: ignored (still acknowledged with R).
- disp_valid&disp_ready at an edge: disp_valid ← 0, DSR[15] ← 1. disp_data is stable while disp_valid=1.
- MCR: fully writable; mcr_run=MCR[15].
- MIO_EN dropping during WAIT is a protocol violation; the access completes anyway.

Test Plan:
- Reset, write RAM x3000 ← xBEEF, read x3000 (LATENCY=2) → R pulses exactly 2 edges after each acceptance, one cycle wide; mio_out=xBEEF; no R ever without MIO_EN.
- Back-to-back reads x3001, x3002 preloaded x1111/x2222 → two single-cycle R pulses separated by one idle cycle, mio_out=x1111 then x2222.
- kb_valid with 'A' (x41) → KBSR=x8000. Write KBSR ← x4000 → kb_int=1. Read KBDR → x0041 and KBSR[15]=0. Second char before the read → kb_overrun pulse, KBDR stays x0041.
- Write DDR ← x0048 with disp_ready=0 → disp_valid=1, disp_data=x48, DSR reads x0000. Second DDR write is dropped. disp_ready=1 for one cycle → disp_valid=0, DSR reads x8000.
- Write xFFFE ← x0000 → mcr_run=0; read xFE10 → x0000. Assert reset during WAIT of a write to x3000 → R stays 0, RAM[x000] unchanged.
- LATENCY=1 build: read acknowledged one edge after acceptance; simultaneous kb_valid and KBDR-read commit → old char returned, KBSR[15]=1, no overrun.
